// File: rtl/fetch_stage_if.sv
// Fetch stage bus: instruction-memory request/response, decode handoff and redirect.
// The fetch stage takes the master view; the memory/decode environment takes the slave view.
interface fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the PC, issues in-order word reads, buffers returned words
// in a small FIFO for decode, predecodes J-type jumps and honours external redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  // Discard can accumulate across redirects, so it gets one extra bit to reach 2*DEPTH.
  localparam int unsigned DW = $clog2(2 * DEPTH) + 1;
  localparam int unsigned SW = DW + 1;

  logic [31:0]   r_pc;
  logic [CW-1:0] r_inflight;
  logic [DW-1:0] r_discard;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [31:0]   r_last_instr;
  logic [31:0]   r_last_pc;
  logic [31:0]   r_mem_instr [DEPTH];
  logic [31:0]   r_mem_pc    [DEPTH];

  logic [CW:0]   w_occ_sum;
  logic          w_req_valid;
  logic          w_req_hs;
  logic          w_rsp_take;
  logic          w_rsp_drop;
  logic          w_rsp_word;
  logic [31:0]   w_rsp_pc;
  logic [31:0]   w_seq_pc;
  logic [31:0]   w_jump_target;
  logic          w_push;
  logic          w_jump;
  logic          w_head_valid;
  logic          w_pop;
  logic [CW-1:0] w_inflight_post;
  logic [DW-1:0] w_discard_post;
  logic [SW-1:0] w_discard_sum;
  logic [DW-1:0] w_discard_sat;
  logic [31:0]   w_pc_next;
  logic [CW-1:0] w_inflight_next;
  logic [DW-1:0] w_discard_next;
  logic [31:0]   w_instruction;
  logic [31:0]   w_instr_pc;

  // Handshake decode, response classification and J-type predecode.
  always_comb begin
    w_occ_sum    = (CW + 1)'(r_count) + (CW + 1)'(r_inflight);
    w_req_valid  = !rst && !bus.redirect_valid && (w_occ_sum < (CW + 1)'(DEPTH));
    w_req_hs     = w_req_valid && bus.imem_req_ready;
    w_rsp_take   = bus.imem_rsp_valid && ((r_inflight != '0) || (r_discard != '0));
    // Stale words are always older than live ones, so they are consumed first.
    w_rsp_drop   = w_rsp_take && (r_discard != '0);
    w_rsp_word   = w_rsp_take && (r_discard == '0);
    // Live in-flight requests are consecutive words ending just below the PC.
    w_rsp_pc     = r_pc - (32'(r_inflight) << 2);
    w_seq_pc     = w_rsp_pc + 32'd4;
    w_jump_target = (w_seq_pc & 32'hF000_0000) | {4'b0000, bus.imem_rsp_data[25:0], 2'b00};
    w_push       = w_rsp_word && !bus.redirect_valid;
    w_jump       = w_push && (bus.imem_rsp_data[31:26] == 6'b000010);
    w_head_valid = (r_count != '0);
    w_pop        = w_head_valid && bus.instr_ready && !bus.redirect_valid;
  end

  // Next PC and in-flight/discard accounting; redirect outranks a jump outranks sequential.
  always_comb begin
    w_inflight_post = r_inflight - CW'(w_rsp_word);
    w_discard_post  = r_discard - DW'(w_rsp_drop);
    // A request accepted alongside a jump already targets the wrong path.
    w_discard_sum   = SW'(w_discard_post) + SW'(w_inflight_post) + SW'(w_req_hs);
    w_discard_sat   = (w_discard_sum > SW'(2 * DEPTH)) ? DW'(2 * DEPTH)
                                                       : w_discard_sum[DW-1:0];
    w_pc_next       = r_pc;
    w_inflight_next = w_inflight_post + CW'(w_req_hs);
    w_discard_next  = w_discard_post;
    if (bus.redirect_valid) begin
      w_pc_next       = bus.redirect_pc & 32'hFFFF_FFFC;
      w_inflight_next = '0;
      w_discard_next  = w_discard_sat;
    end else if (w_jump) begin
      w_pc_next       = w_jump_target;
      w_inflight_next = '0;
      w_discard_next  = w_discard_sat;
    end else if (w_req_hs) begin
      w_pc_next       = r_pc + 32'd4;
    end
  end

  // Head of the buffer, or the last shown value once the buffer is empty.
  always_comb begin
    w_instruction = w_head_valid ? r_mem_instr[r_rd_ptr] : r_last_instr;
    w_instr_pc    = w_head_valid ? r_mem_pc[r_rd_ptr]    : r_last_pc;
  end

  // PC and request/discard counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_inflight <= '0;
      r_discard  <= '0;
    end else begin
      r_pc       <= w_pc_next;
      r_inflight <= w_inflight_next;
      r_discard  <= w_discard_next;
    end
  end

  // Buffer pointers, occupancy and the held output value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count      <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_last_instr <= '0;
      r_last_pc    <= '0;
    end else begin
      r_last_instr <= w_instruction;
      r_last_pc    <= w_instr_pc;
      if (bus.redirect_valid) begin
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  // Buffer storage; contents only matter while counted as occupied.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_wr_ptr] <= bus.imem_rsp_data;
      r_mem_pc[r_wr_ptr]    <= w_rsp_pc;
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.instr_valid    = w_head_valid;
  assign bus.instruction    = w_instruction;
  assign bus.instr_pc       = w_instr_pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order, fixed-latency instruction memory model.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_stage_if f ();

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (f.master)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned lat      = 1;
  logic [31:0] q_addr[$];
  int unsigned q_due[$];
  logic [31:0] rsp_addr;
  logic [31:0] exp_pc;
  bit          jmode;
  logic [31:0] jaddr   = 32'h0000_0010;
  logic [31:0] jword   = 32'h0800_0040;
  logic [31:0] jtarget = 32'h0000_0100;
  int          n_dlv;
  int          n0;
  bit          saw_j;
  bit          saw_t;
  bit          found;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (jmode && a == jaddr) return jword;
    return 32'h0000_0011 + (a >> 2);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, then advance the memory model just after posedge.
  task automatic cycle();
    @(negedge clk);
    if (!rst) begin
      if (f.imem_req_valid && f.imem_req_ready) begin
        q_addr.push_back(f.imem_req_addr);
        q_due.push_back(cyc + lat);
      end
      if (f.instr_valid && f.instr_ready && !f.redirect_valid) begin
        check_eq("dlv_pc", f.instr_pc, exp_pc);
        check_eq("dlv_ins", f.instruction, mem_word(exp_pc));
        n_dlv++;
        if (f.instruction == jword) saw_j = 1'b1;
        if (f.instr_pc == jtarget) saw_t = 1'b1;
        if (jmode && exp_pc == jaddr) exp_pc = jtarget;
        else exp_pc = exp_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      rsp_addr = q_addr.pop_front();
      void'(q_due.pop_front());
      f.imem_rsp_valid = 1'b1;
      f.imem_rsp_data  = mem_word(rsp_addr);
    end else begin
      f.imem_rsp_valid = 1'b0;
      f.imem_rsp_data  = 32'h0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_valid"}, 32'(f.imem_req_valid), 32'h0);
    check_eq({tag, "_req_addr"}, f.imem_req_addr, 32'h0);
    check_eq({tag, "_instr_valid"}, 32'(f.instr_valid), 32'h0);
    check_eq({tag, "_instruction"}, f.instruction, 32'h0);
    check_eq({tag, "_instr_pc"}, f.instr_pc, 32'h0);
  endtask

  task automatic do_reset(input int unsigned l);
    rst = 1'b1;
    f.redirect_valid = 1'b0;
    q_addr.delete();
    q_due.delete();
    lat = l;
    run(2);
    check_reset_outputs("rst");
    rst    = 1'b0;
    exp_pc = 32'h0;
    n_dlv  = 0;
    saw_j  = 1'b0;
    saw_t  = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    f.imem_req_ready = 1'b1;
    f.imem_rsp_valid = 1'b0;
    f.imem_rsp_data  = 32'h0;
    f.instr_ready    = 1'b1;
    f.redirect_valid = 1'b0;
    f.redirect_pc    = 32'h0;
    jmode            = 1'b0;

    // Sequential stream, 1-cycle memory.
    do_reset(1);
    run(20);
    check_eq("t1_dlv_count", 32'(n_dlv >= 8), 32'h1);

    // Decode stall: buffer fills to DEPTH, requests stop, then in-order drain.
    f.instr_ready = 1'b0;
    run(10);
    check_eq("t2_instr_valid", 32'(f.instr_valid), 32'h1);
    check_eq("t2_req_valid", 32'(f.imem_req_valid), 32'h0);
    check_eq("t2_head_pc", f.instr_pc, exp_pc);
    check_eq("t2_head_ins", f.instruction, mem_word(exp_pc));
    n0 = n_dlv;
    f.instr_ready = 1'b1;
    run(10);
    check_eq("t2_drain", 32'(n_dlv - n0 >= 4), 32'h1);

    // J-type at 0x10 redirects to 0x100; 0x14/0x18 must not reach decode.
    jmode = 1'b1;
    do_reset(1);
    run(40);
    check_eq("t3_saw_jump", 32'(saw_j), 32'h1);
    check_eq("t3_saw_target", 32'(saw_t), 32'h1);
    check_eq("t3_dlv_count", 32'(n_dlv >= 8), 32'h1);
    jmode = 1'b0;

    // External redirect to 0x203 with two requests in flight (latency 3).
    do_reset(3);
    run(2);
    f.redirect_valid = 1'b1;
    f.redirect_pc    = 32'h0000_0203;
    #1;
    check_eq("t4_redirect_noreq", 32'(f.imem_req_valid), 32'h0);
    exp_pc = 32'h0000_0200;
    cycle();
    f.redirect_valid = 1'b0;
    run(25);
    check_eq("t4_dlv_count", 32'(n_dlv >= 3), 32'h1);

    // Redirect with a full buffer flushes it.
    f.instr_ready = 1'b0;
    run(12);
    check_eq("t4b_full_valid", 32'(f.instr_valid), 32'h1);
    check_eq("t4b_head_pc", f.instr_pc, exp_pc);
    f.redirect_valid = 1'b1;
    f.redirect_pc    = 32'h0000_0300;
    exp_pc           = 32'h0000_0300;
    cycle();
    f.redirect_valid = 1'b0;
    check_eq("t4b_flushed", 32'(f.instr_valid), 32'h0);
    f.instr_ready = 1'b1;
    n_dlv = 0;
    run(25);
    check_eq("t4b_dlv_count", 32'(n_dlv >= 3), 32'h1);

    // Redirect in the same cycle as the J-type response: redirect wins.
    jmode = 1'b1;
    do_reset(1);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle();
      if (f.imem_rsp_valid && rsp_addr == jaddr) found = 1'b1;
    end
    check_eq("t5_jump_rsp_seen", 32'(found), 32'h1);
    f.redirect_valid = 1'b1;
    f.redirect_pc    = 32'h0000_0400;
    exp_pc           = 32'h0000_0400;
    n0               = n_dlv;
    cycle();
    f.redirect_valid = 1'b0;
    run(25);
    check_eq("t5_jump_dropped", 32'(saw_j), 32'h0);
    check_eq("t5_dlv_count", 32'(n_dlv - n0 >= 3), 32'h1);
    jmode = 1'b0;

    // Reset mid-stream while a response is on the bus; a stale response follows release.
    do_reset(1);
    run(15);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (f.imem_rsp_valid) found = 1'b1;
      else cycle();
    end
    check_eq("t6_rsp_seen", 32'(found), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    q_addr.delete();
    q_due.delete();
    run(1);
    f.imem_rsp_valid = 1'b1;
    f.imem_rsp_data  = 32'hDEAD_BEEF;
    rst    = 1'b0;
    exp_pc = 32'h0;
    n_dlv  = 0;
    run(20);
    check_eq("t6_dlv_count", 32'(n_dlv >= 8), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
